// File: rtl/grid_nav_driver.sv
// rtl/grid_nav_driver.sv - closed-loop greedy robot navigator for the grid planning model
//
// Tracks two obstacles from their per-cycle move strobes and drives one-hot
// robot move commands toward (GOAL_X, GOAL_Y).
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   end_init                   obstacle initialisation finished; starts the run from IDLE
//   obs{1,2}_{up,down,left,right}  obstacle move strobes
//   error                      collision flag from the planning model (honoured in RUN only)
//   robot                      high while the run phase is active
//   robot_{up,down,left,right} registered one-hot move command
//   done, blocked, fault       sticky terminal-state flags
//   step_cnt                   moves issued, saturating at 255
module grid_nav_driver #(
  parameter int GRID_N   = 8,
  parameter int CW       = 3,
  parameter int START_X  = 0,
  parameter int START_Y  = 0,
  parameter int GOAL_X   = 3,
  parameter int GOAL_Y   = 2,
  parameter int OBS1_X   = 1,
  parameter int OBS1_Y   = 0,
  parameter int OBS2_X   = 5,
  parameter int OBS2_Y   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       end_init,
  input  logic       obs1_up,
  input  logic       obs1_down,
  input  logic       obs1_left,
  input  logic       obs1_right,
  input  logic       obs2_up,
  input  logic       obs2_down,
  input  logic       obs2_left,
  input  logic       obs2_right,
  input  logic       error,
  output logic       robot,
  output logic       robot_up,
  output logic       robot_down,
  output logic       robot_left,
  output logic       robot_right,
  output logic       done,
  output logic       blocked,
  output logic       fault,
  output logic [7:0] step_cnt
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAXC = CW'(GRID_N - 1);
  localparam logic [CW-1:0] GX   = CW'(GOAL_X);
  localparam logic [CW-1:0] GY   = CW'(GOAL_Y);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE, S_BLOCKED, S_FAULT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   pos_x, pos_y;
  logic [CW-1:0]   obs1_x, obs1_y, obs2_x, obs2_y;
  logic [CW-1:0]   obs1_nx, obs1_ny, obs2_nx, obs2_ny;
  logic [WW-1:0]   wait_cnt;
  logic [3:0]      cmd_q;     // {up, down, left, right}
  logic [3:0]      mv_cmd;
  logic [CW-1:0]   next_x, next_y;
  logic [CW-1:0]   h_x, v_y;
  logic            h_free, v_free, moving, do_move, at_goal;

  // One-cell move for a single strobe, clamped at the grid edge. Zero or
  // several strobes leave the obstacle where it is.
  function automatic logic [2*CW-1:0] track(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                            input logic [3:0] s);
    logic [CW-1:0] nx, ny;
    nx = x;
    ny = y;
    case (s)
      4'b1000: if (y != MAXC)  ny = y + 1'b1;
      4'b0100: if (y != '0)    ny = y - 1'b1;
      4'b0010: if (x != '0)    nx = x - 1'b1;
      4'b0001: if (x != MAXC)  nx = x + 1'b1;
      default: ;
    endcase
    return {nx, ny};
  endfunction

  always_comb begin
    {obs1_nx, obs1_ny} = track(obs1_x, obs1_y, {obs1_up, obs1_down, obs1_left, obs1_right});
    {obs2_nx, obs2_ny} = track(obs2_x, obs2_y, {obs2_up, obs2_down, obs2_left, obs2_right});
  end

  // Candidates are checked against where the obstacles will be after this edge.
  always_comb begin
    h_x    = (pos_x < GX) ? pos_x + 1'b1 : pos_x - 1'b1;
    v_y    = (pos_y < GY) ? pos_y + 1'b1 : pos_y - 1'b1;
    h_free = (pos_x != GX) &&
             !((h_x == obs1_nx && pos_y == obs1_ny) || (h_x == obs2_nx && pos_y == obs2_ny));
    v_free = (pos_y != GY) &&
             !((pos_x == obs1_nx && v_y == obs1_ny) || (pos_x == obs2_nx && v_y == obs2_ny));
    mv_cmd = 4'b0000;
    next_x = pos_x;
    next_y = pos_y;
    if (h_free) begin
      next_x = h_x;
      mv_cmd = (pos_x < GX) ? 4'b0001 : 4'b0010;
    end else if (v_free) begin
      next_y = v_y;
      mv_cmd = (pos_y < GY) ? 4'b1000 : 4'b0100;
    end
    moving  = |mv_cmd;
    at_goal = (pos_x == GX) && (pos_y == GY);
    do_move = (state_q == S_RUN) && !error && moving;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (end_init) state_d = at_goal ? S_DONE : S_RUN;
      S_RUN: begin
        if (error)                                        state_d = S_FAULT;
        else if (moving && next_x == GX && next_y == GY)  state_d = S_DONE;
        else if (!moving && wait_cnt == WW'(MAX_WAIT - 1)) state_d = S_BLOCKED;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pos_x    <= CW'(START_X);
      pos_y    <= CW'(START_Y);
      obs1_x   <= CW'(OBS1_X);
      obs1_y   <= CW'(OBS1_Y);
      obs2_x   <= CW'(OBS2_X);
      obs2_y   <= CW'(OBS2_Y);
      wait_cnt <= '0;
      cmd_q    <= 4'b0000;
      step_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      obs1_x  <= obs1_nx;
      obs1_y  <= obs1_ny;
      obs2_x  <= obs2_nx;
      obs2_y  <= obs2_ny;
      cmd_q   <= do_move ? mv_cmd : 4'b0000;
      if (do_move) begin
        pos_x    <= next_x;
        pos_y    <= next_y;
        wait_cnt <= '0;
        if (step_cnt != 8'hFF) step_cnt <= step_cnt + 8'd1;
      end else if (state_q == S_RUN && !error) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign robot       = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign blocked     = (state_q == S_BLOCKED);
  assign fault       = (state_q == S_FAULT);
  assign robot_up    = cmd_q[3];
  assign robot_down  = cmd_q[2];
  assign robot_left  = cmd_q[1];
  assign robot_right = cmd_q[0];

endmodule

// File: tb/tb_grid_nav_driver.sv
// tb/tb_grid_nav_driver.sv - directed self-checking bench for grid_nav_driver
module tb_grid_nav_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       end_init = 1'b0;
  logic       obs1_up = 1'b0, obs1_down = 1'b0, obs1_left = 1'b0, obs1_right = 1'b0;
  logic       obs2_up = 1'b0, obs2_down = 1'b0, obs2_left = 1'b0, obs2_right = 1'b0;
  logic       error = 1'b0;
  logic       robot, robot_up, robot_down, robot_left, robot_right;
  logic       done, blocked, fault;
  logic [7:0] step_cnt;

  int tests = 0;
  int fails = 0;

  logic [3:0] seq_clear [5];
  logic [3:0] seq_obs1  [5];

  always #5 clk = ~clk;

  grid_nav_driver dut (
    .clk(clk), .rst_n(rst_n), .end_init(end_init),
    .obs1_up(obs1_up), .obs1_down(obs1_down), .obs1_left(obs1_left), .obs1_right(obs1_right),
    .obs2_up(obs2_up), .obs2_down(obs2_down), .obs2_left(obs2_left), .obs2_right(obs2_right),
    .error(error), .robot(robot),
    .robot_up(robot_up), .robot_down(robot_down), .robot_left(robot_left), .robot_right(robot_right),
    .done(done), .blocked(blocked), .fault(fault), .step_cnt(step_cnt)
  );

  function automatic logic [3:0] cmds();
    return {robot_up, robot_down, robot_left, robot_right};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    end_init = 1'b1;
    cyc();
    end_init = 1'b0;
  endtask

  initial begin
    seq_clear[0] = 4'b0001; seq_clear[1] = 4'b0001; seq_clear[2] = 4'b0001;
    seq_clear[3] = 4'b1000; seq_clear[4] = 4'b1000;
    seq_obs1[0]  = 4'b1000; seq_obs1[1]  = 4'b0001; seq_obs1[2]  = 4'b0001;
    seq_obs1[3]  = 4'b0001; seq_obs1[4]  = 4'b1000;

    // Reset state
    do_reset();
    check("rst_cmds", cmds(), 4'b0000);
    check("rst_flags", {robot, done, blocked, fault}, 4'b0000);
    check("rst_step", step_cnt, 8'd0);
    check("rst_pos", {dut.pos_x, dut.pos_y}, {3'd0, 3'd0});

    // Edge clamp and multi-strobe hold
    obs2_right = 1'b1;
    repeat (10) cyc();
    obs2_right = 1'b0;
    check("obs2_clamp", {dut.obs2_x, dut.obs2_y}, {3'd7, 3'd5});
    obs1_up = 1'b1; obs1_left = 1'b1;
    cyc();
    obs1_up = 1'b0; obs1_left = 1'b0;
    check("obs1_multi", {dut.obs1_x, dut.obs1_y}, {3'd1, 3'd0});
    obs1_down = 1'b1;
    cyc();
    obs1_down = 1'b0;
    check("obs1_clamp_low", {dut.obs1_x, dut.obs1_y}, {3'd1, 3'd0});

    // Clear path: obs1 moved to (1,7), obs2 at (5,5) is off the path
    do_reset();
    obs1_up = 1'b1;
    repeat (7) cyc();
    obs1_up = 1'b0;
    check("obs1_moved", {dut.obs1_x, dut.obs1_y}, {3'd1, 3'd7});
    start_run();
    check("e0_robot", robot, 1'b1);
    check("e0_cmds", cmds(), 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("clear_cmd%0d", i + 1), cmds(), seq_clear[i]);
      check($sformatf("clear_done%0d", i + 1), done, (i == 4) ? 1'b1 : 1'b0);
    end
    check("clear_pos", {dut.pos_x, dut.pos_y}, {3'd3, 3'd2});
    cyc();
    check("clear_after_cmds", cmds(), 4'b0000);
    check("clear_after_flags", {robot, done}, 2'b01);
    check("clear_step", step_cnt, 8'd5);

    // Asynchronous reset mid-run after 3 moves
    do_reset();
    obs1_up = 1'b1;
    repeat (7) cyc();
    obs1_up = 1'b0;
    start_run();
    repeat (3) cyc();
    check("mid_cmd3", cmds(), 4'b0001);
    check("mid_step3", step_cnt, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cmds", cmds(), 4'b0000);
    check("async_flags", {robot, done, blocked, fault}, 4'b0000);
    check("async_step", step_cnt, 8'd0);
    check("async_pos", {dut.pos_x, dut.pos_y}, {3'd0, 3'd0});
    check("async_obs1", {dut.obs1_x, dut.obs1_y}, {3'd1, 3'd0});
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    check("idle_hold", {robot, cmds()}, 5'b0);

    // Obstacle 1 at (1,0): first move goes up
    start_run();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("obs1_cmd%0d", i + 1), cmds(), seq_obs1[i]);
    end
    check("obs1_done", done, 1'b1);
    check("obs1_step", step_cnt, 8'd5);

    // Boxed in: obs2 walked to (0,1), obs1 at (1,0)
    do_reset();
    obs2_left = 1'b1;
    repeat (5) cyc();
    obs2_left = 1'b0;
    obs2_down = 1'b1;
    repeat (4) cyc();
    obs2_down = 1'b0;
    check("obs2_box", {dut.obs2_x, dut.obs2_y}, {3'd0, 3'd1});
    start_run();
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check($sformatf("box_wait%0d", i), {blocked, cmds()}, 5'b0);
    end
    cyc();
    check("box_blocked", {robot, blocked, cmds()}, 6'b010000);
    check("box_step", step_cnt, 8'd0);

    // Error during the second move
    do_reset();
    obs1_up = 1'b1;
    repeat (7) cyc();
    obs1_up = 1'b0;
    start_run();
    cyc();
    check("err_first", cmds(), 4'b0001);
    error = 1'b1;
    cyc();
    error = 1'b0;
    check("err_cmds", cmds(), 4'b0000);
    check("err_flags", {robot, fault}, 2'b01);
    check("err_step", step_cnt, 8'd1);
    check("err_pos", {dut.pos_x, dut.pos_y}, {3'd1, 3'd0});
    cyc();
    check("err_sticky", {fault, cmds()}, 5'b10000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Commands must never overlap
  always @(negedge clk) begin
    if (rst_n) begin
      assert ($countones(cmds()) <= 1) else begin
        fails++;
        $error("FAIL onehot: observed %b expected at most one bit", cmds());
      end
    end
  end

endmodule
